ext_interleaver: RTL and testbench
==================================

# ext_interleaver

Extrinsic interleaver/deinterleaver buffer between the two max-log-MAP SISO decoders of the turbo loop. It consumes one frame of SISO output LLRs, forms saturated extrinsic values (LLR − systematic − a-priori), and stores them. It then replays them in permuted (interleave) or natural (deinterleave) order as the next SISO's a-priori/extrinsic input stream. Frame length matches the SISO trellis length including the two tail steps.

## Interface
- DATA_SIZE, 10: width of the signed SISO LLR input.
- EXT_SIZE, 7: width of the signed sys/apr inputs and the extrinsic output.
- BLOCK_LEN, 7: samples per frame (input_size + 2).
- PERM_STEP, 3: permutation step P, with pi(i) = (P·i) mod BLOCK_LEN. Requires 0 < P < BLOCK_LEN and gcd(P, BLOCK_LEN) = 1.
- clk_i  in  1  clock; the block uses one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- llr_valid_i  in  1  input beat valid.
- llr_i  in  DATA_SIZE  signed SISO LLR.
- sys_i  in  EXT_SIZE  signed systematic sample aligned with llr_i.
- apr_i  in  EXT_SIZE  signed a-priori value the SISO used for this sample.
- deint_i  in  1  0 = interleave (natural write, permuted read); 1 = deinterleave (permuted write, natural read).
- in_ready_o  out  1  block accepts input.
- ext_valid_o  out  1  output beat valid.
- ext_o  out  EXT_SIZE  signed extrinsic value.
- out_ready_i  in  1  consumer accepts output.
- frame_done_o  out  1  one-cycle pulse after the last output beat.

## Operation
- Storage: BLOCK_LEN × EXT_SIZE register array. The contents are not reset.
- Extrinsic computation: d = llr_i − sys_i − apr_i.
  - Operands are sign-extended to DATA_SIZE+2 bits.
  - d is saturated to [−2^(EXT_SIZE−1), 2^(EXT_SIZE−1)−1]; for defaults this is [−64, 63].
- Permuted address generation uses no multiplier:
  - The address starts at 0.
  - Each step adds P; if the sum is ≥ BLOCK_LEN, subtract BLOCK_LEN.
- FSM states:
  - FILL
    - in_ready_o = 1.
    - Each beat with llr_valid_i & in_ready_o writes d to the array. The write address is the count i when deint = 0, or pi(i) when deint = 1.
    - deint_i is latched on the first accepted beat of a frame and held for the whole frame.
    - After the BLOCK_LEN-th accepted beat, the FSM moves to DRAIN.
  - DRAIN
    - in_ready_o = 0 and ext_valid_o = 1.
    - ext_o = array[rd_addr]. rd_addr is pi(j) when deint = 0, or j when deint = 1, where j is the output count.
    - On out_ready_i & ext_valid_o, j and rd_addr advance.
    - The last accepted beat returns the FSM to FILL, pulses frame_done_o and clears both counters.
- Reset values: state FILL, counters 0, rd_addr 0, latched deint 0, in_ready_o 1, ext_valid_o 0, ext_o 0, frame_done_o 0.

## Timing
- A write occurs at the clock edge that accepts the beat; there is no input bubble between beats.
- DRAIN is entered on the cycle after the last input beat. ext_valid_o is 1 in that cycle, with ext_o already valid.
- Throughput: one beat per cycle in each phase. Frame period = 2·BLOCK_LEN cycles with no stalls.
- ext_o is driven only from registers (array plus rd_addr register) and is stable while stalled (ext_valid_o & !out_ready_i).
- frame_done_o is registered and high for exactly the cycle following the last output handshake. In that same cycle in_ready_o = 1.
- llr_valid_i in DRAIN is ignored; the upstream block must hold its data.
- Reset mid-FILL or mid-DRAIN aborts the frame:
  - The next cycle is FILL with counts at 0.
  - No frame_done_o pulse is produced.
  - Stale array data is overwritten by the next frame.

## Configuration
- EXT_SCALE_EN defined: d is scaled by 0.75 before saturation, computed as d − (d >>> 2) with an arithmetic shift, at full width.
- EXT_SCALE_EN undefined: d is saturated unscaled. The scaling logic is absent.

## Test plan
- Interleave: defaults, sys = apr = 0, deint = 0, llr = 10, 20, 30, 40, 50, 60, 70 → ext_o = 10, 40, 70, 30, 60, 20, 50, then a frame_done_o pulse.
- Deinterleave: same input with deint = 1 → ext_o = 10, 60, 40, 20, 70, 50, 30.
- Saturation (scale off):
  - llr = 200, sys = −10, apr = 0 → 63.
  - llr = −300, sys = 5, apr = 0 → −64.
  - llr = 20, sys = 3, apr = 2 → 15.
- EXT_SCALE_EN defined:
  - d = 40 → 30.
  - d = −41 → −30.
  - llr = 200, sys = −10 → 63.
- Backpressure: hold out_ready_i = 0 for 3 cycles at output beat 2 → ext_o holds 70 and ext_valid_o stays 1. in_ready_o stays 0 and llr_valid_i pulses are ignored.
- Reset: assert rst_i for one cycle mid-DRAIN after beat 3 → no frame_done_o pulse, in_ready_o = 1 on the next cycle. The following frame reproduces the interleave scenario exactly.

Source files
------------

// File: rtl/ext_interleaver_if.sv
// Handshake bundle of the extrinsic interleaver: LLR input stream toward the block, extrinsic output stream out of it.
// slave is the block side; master is the producer/consumer side.
interface ext_interleaver_if #(
    parameter int DATA_SIZE = 10,
    parameter int EXT_SIZE  = 7
);
    logic                        llr_valid_i;
    logic signed [DATA_SIZE-1:0] llr_i;
    logic signed [EXT_SIZE-1:0]  sys_i;
    logic signed [EXT_SIZE-1:0]  apr_i;
    logic                        deint_i;
    logic                        in_ready_o;
    logic                        ext_valid_o;
    logic signed [EXT_SIZE-1:0]  ext_o;
    logic                        out_ready_i;
    logic                        frame_done_o;

    modport slave (
        input  llr_valid_i, llr_i, sys_i, apr_i, deint_i, out_ready_i,
        output in_ready_o, ext_valid_o, ext_o, frame_done_o
    );

    modport master (
        output llr_valid_i, llr_i, sys_i, apr_i, deint_i, out_ready_i,
        input  in_ready_o, ext_valid_o, ext_o, frame_done_o
    );
endinterface

// File: rtl/ext_interleaver.sv
// Extrinsic interleave/deinterleave frame buffer; EXT_SCALE_EN adds 0.75 scaling of the extrinsic before saturation.
// Output starts the cycle after the last input beat; out_ready_i low holds ext_o, input is refused while draining.
module ext_interleaver #(
    parameter int DATA_SIZE = 10,
    parameter int EXT_SIZE  = 7,
    parameter int BLOCK_LEN = 7,
    parameter int PERM_STEP = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ext_interleaver_if.slave  bus
);
    localparam int ADDR_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int W      = DATA_SIZE + 2;
    localparam int MAXV   = (2 ** (EXT_SIZE - 1)) - 1;
    localparam logic signed [W-1:0] SAT_MAX = W'(MAXV);
    localparam logic signed [W-1:0] SAT_MIN = W'(-MAXV - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]          perm_q, perm_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic                       deint_q, deint_d;
    logic                       done_q, done_d;
    logic signed [EXT_SIZE-1:0] mem_q [BLOCK_LEN];

    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       deint_eff;
    logic                       last;
    logic [ADDR_W:0]            perm_sum;
    logic [ADDR_W-1:0]          perm_next;

    logic signed [W-1:0]        llr_x, sys_x, apr_x, d_raw, d_sc;
    logic signed [EXT_SIZE-1:0] ext_sat;

    assign llr_x = {{(W-DATA_SIZE){bus.llr_i[DATA_SIZE-1]}}, bus.llr_i};
    assign sys_x = {{(W-EXT_SIZE){bus.sys_i[EXT_SIZE-1]}}, bus.sys_i};
    assign apr_x = {{(W-EXT_SIZE){bus.apr_i[EXT_SIZE-1]}}, bus.apr_i};
    assign d_raw = llr_x - sys_x - apr_x;

`ifdef EXT_SCALE_EN
    assign d_sc = d_raw - (d_raw >>> 2);
`else
    assign d_sc = d_raw;
`endif

    always_comb begin
        if (d_sc > SAT_MAX)      ext_sat = EXT_SIZE'(SAT_MAX);
        else if (d_sc < SAT_MIN) ext_sat = EXT_SIZE'(SAT_MIN);
        else                     ext_sat = EXT_SIZE'(d_sc);
    end

    // pi(i+1) = pi(i) + P mod BLOCK_LEN, one conditional subtract since pi(i) < BLOCK_LEN
    assign perm_sum  = {1'b0, perm_q} + (ADDR_W+1)'(PERM_STEP);
    assign perm_next = (perm_sum >= (ADDR_W+1)'(BLOCK_LEN))
                     ? ADDR_W'(perm_sum - (ADDR_W+1)'(BLOCK_LEN))
                     : perm_sum[ADDR_W-1:0];

    assign last      = (cnt_q == ADDR_W'(BLOCK_LEN - 1));
    assign deint_eff = (cnt_q == '0) ? bus.deint_i : deint_q;
    assign wr_addr   = deint_eff ? perm_q : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        perm_d    = perm_q;
        rd_addr_d = rd_addr_q;
        deint_d   = deint_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.llr_valid_i) begin
                    wr_en   = 1'b1;
                    deint_d = deint_eff;
                    if (last) begin
                        state_d   = DRAIN;
                        cnt_d     = '0;
                        perm_d    = '0;
                        rd_addr_d = '0;
                    end else begin
                        cnt_d  = cnt_q + ADDR_W'(1);
                        perm_d = perm_next;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready_i) begin
                    if (last) begin
                        state_d   = FILL;
                        cnt_d     = '0;
                        perm_d    = '0;
                        rd_addr_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + ADDR_W'(1);
                        perm_d    = perm_next;
                        rd_addr_d = deint_q ? (cnt_q + ADDR_W'(1)) : perm_next;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            perm_q    <= '0;
            rd_addr_q <= '0;
            deint_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            perm_q    <= perm_d;
            rd_addr_q <= rd_addr_d;
            deint_q   <= deint_d;
            done_q    <= done_d;
        end
    end

    // Storage is deliberately unreset; every frame rewrites all entries before they are read.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) mem_q[wr_addr] <= ext_sat;
    end

    assign bus.in_ready_o   = (state_q == FILL);
    assign bus.ext_valid_o  = (state_q == DRAIN);
    assign bus.ext_o        = (state_q == DRAIN) ? mem_q[rd_addr_q] : '0;
    assign bus.frame_done_o = done_q;
endmodule

// File: tb/tb_ext_interleaver.sv
// Directed bench for ext_interleaver with a scoreboard queue of expected extrinsic outputs.
module tb_ext_interleaver;
    localparam int DATA_SIZE = 10;
    localparam int EXT_SIZE  = 7;
    localparam int N         = 7;
    localparam int P         = 3;

    logic clk;
    logic rst;

    ext_interleaver_if #(.DATA_SIZE(DATA_SIZE), .EXT_SIZE(EXT_SIZE)) bus ();

    ext_interleaver #(
        .DATA_SIZE(DATA_SIZE), .EXT_SIZE(EXT_SIZE), .BLOCK_LEN(N), .PERM_STEP(P)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int l_ramp [N] = '{10, 20, 30, 40, 50, 60, 70};
    int zeros  [N] = '{0, 0, 0, 0, 0, 0, 0};
    int l_sat  [N] = '{200, -300, 20, 40, -41, 0, -64};
    int s_sat  [N] = '{-10, 5, 3, 0, 0, 0, 0};
    int a_sat  [N] = '{0, 0, 2, 0, 0, 0, 1};

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int l, input int s, input int a);
        int d;
        d = l - s - a;
`ifdef EXT_SCALE_EN
        d = d - (d >>> 2);
`endif
        if (d > 63)  d = 63;
        if (d < -64) d = -64;
        return d;
    endfunction

    task automatic send(input int l [N], input int s [N], input int a [N], input bit deint);
        int mem [N];
        for (int i = 0; i < N; i++) begin
            mem[deint ? (P * i) % N : i] = model(l[i], s[i], a[i]);
        end
        for (int j = 0; j < N; j++) begin
            exp_q.push_back(mem[deint ? j : (P * j) % N]);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("in_ready_fill", 32'(bus.in_ready_o), 1);
            bus.llr_valid_i = 1'b1;
            bus.llr_i       = DATA_SIZE'(l[i]);
            bus.sys_i       = EXT_SIZE'(s[i]);
            bus.apr_i       = EXT_SIZE'(a[i]);
            // deint must be taken from the first beat only
            bus.deint_i     = (i == 0) ? deint : ~deint;
        end
    endtask

    task automatic drain(input int n_beats, input int stall_at, input int stall_len);
        int got = 0;
        int stalled = 0;
        int budget = 100;
        while (got < n_beats && budget > 0) begin
            @(negedge clk);
            budget--;
            chk("ext_valid", 32'(bus.ext_valid_o), 1);
            chk("in_ready_drain", 32'(bus.in_ready_o), 0);
            chk("frame_done_early", 32'(bus.frame_done_o), 0);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'(exp_q.size()), 1000);
                break;
            end
            if (got == stall_at && stalled < stall_len) begin
                bus.out_ready_i = 1'b0;
                bus.llr_valid_i = 1'b1;
                bus.llr_i       = DATA_SIZE'(-100);
                chk("ext_hold", bus.ext_o, exp_q[0]);
                stalled++;
            end else begin
                bus.out_ready_i = 1'b1;
                bus.llr_valid_i = 1'b0;
                chk($sformatf("ext_beat%0d", got), bus.ext_o, exp_q.pop_front());
                got++;
            end
        end
        if (budget == 0) chk("drain_timeout", 32'(got), n_beats);
        if (n_beats == N) begin
            @(negedge clk);
            bus.out_ready_i = 1'b0;
            chk("frame_done_pulse", 32'(bus.frame_done_o), 1);
            chk("in_ready_after", 32'(bus.in_ready_o), 1);
            chk("ext_valid_after", 32'(bus.ext_valid_o), 0);
            @(negedge clk);
            chk("frame_done_single", 32'(bus.frame_done_o), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.llr_valid_i = 1'b0;
        bus.llr_i       = '0;
        bus.sys_i       = '0;
        bus.apr_i       = '0;
        bus.deint_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready_o), 1);
        chk("rst_ext_valid", 32'(bus.ext_valid_o), 0);
        chk("rst_ext_o", bus.ext_o, 0);
        chk("rst_frame_done", 32'(bus.frame_done_o), 0);

        send(l_ramp, zeros, zeros, 1'b0);
        drain(N, -1, 0);

        send(l_ramp, zeros, zeros, 1'b1);
        drain(N, -1, 0);

        send(l_sat, s_sat, a_sat, 1'b0);
        drain(N, -1, 0);

        // stall on output beat 2 with stray llr_valid pulses
        send(l_ramp, zeros, zeros, 1'b0);
        drain(N, 2, 3);

        // abort mid-drain after three beats
        send(l_ramp, zeros, zeros, 1'b0);
        drain(3, -1, 0);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk("abort_no_done", 32'(bus.frame_done_o), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready_o), 1);
        chk("abort_ext_valid", 32'(bus.ext_valid_o), 0);
        chk("abort_no_done2", 32'(bus.frame_done_o), 0);
        exp_q.delete();

        send(l_ramp, zeros, zeros, 1'b0);
        drain(N, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
